// File: rtl/fp32_mul_stream.sv
// fp32_mul_stream: valid/ready wrapper around a combinational FP32 multiplier.
// Operand pairs are registered (S1), multiplied, and the products are queued in
// an in-order result FIFO. The FIFO is protected by credit-based flow control,
// so in_ready_o depends only on registered state and rst.
//
// Optional feature macro: FP32_MUL_FLAGS_EN (adds out_flags_o and per-entry flags).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush_i         synchronous clear of S1 and FIFO (ops_done_o kept)
//   in_valid_i/in_ready_o, in_a_i, in_b_i, in_tag_i     operand stream
//   out_valid_o/out_ready_i, out_result_o, out_tag_o    result stream
//   out_flags_o     {nan, inf, zero, subnormal} of the head result (optional)
//   ops_done_o      number of popped results, modulo 2^16
module fp32_mul_stream #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_a_i,
  input  logic [31:0]      in_b_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic [TAG_W-1:0] out_tag_o,
`ifdef FP32_MUL_FLAGS_EN
  output logic [3:0]       out_flags_o,
`endif
  output logic [15:0]      ops_done_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = AW + 2;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q, s1_a_d;
  logic [31:0]      s1_b_q, s1_b_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    count_q, count_d;
  logic [15:0]      ops_done_q, ops_done_d;

  logic [31:0]      res_mem [FIFO_DEPTH];
  logic [TAG_W-1:0] tag_mem [FIFO_DEPTH];

  logic [31:0]      product;
  logic [CW-1:0]    credit_used;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             empty, full, accept, fifo_wr, pop;

  // Combinational multiplier fed straight from the S1 register
  FP32_Multiplier_Combinatorial u_mul (
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .result_o (product)
  );

  // Pointer-based status: equal pointers = empty, MSBs differ = full
  assign wr_idx      = wr_ptr_q[AW-1:0];
  assign rd_idx      = rd_ptr_q[AW-1:0];
  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);

  // Credit: a slot is reserved for the operand already sitting in S1
  assign credit_used = CW'(count_q) + CW'(s1_valid_q);
  assign in_ready_o  = !rst && (credit_used < CW'(FIFO_DEPTH));
  assign accept      = in_valid_i && in_ready_o;
  assign fifo_wr     = s1_valid_q && !full;
  assign pop         = !empty && out_ready_i;

  assign out_valid_o  = !empty;
  assign out_result_o = empty ? 32'h0 : res_mem[rd_idx];
  assign out_tag_o    = empty ? '0 : tag_mem[rd_idx];
  assign ops_done_o   = ops_done_q;

`ifdef FP32_MUL_FLAGS_EN
  logic [3:0] flag_mem [FIFO_DEPTH];
  logic [3:0] product_flags;

  // Classify the product as it is written
  always_comb begin
    product_flags    = 4'b0000;
    product_flags[3] = (product[30:23] == 8'hFF) && (product[22:0] != 23'h0);
    product_flags[2] = (product[30:23] == 8'hFF) && (product[22:0] == 23'h0);
    product_flags[1] = (product[30:23] == 8'h00) && (product[22:0] == 23'h0);
    product_flags[0] = (product[30:23] == 8'h00) && (product[22:0] != 23'h0);
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i && fifo_wr) begin
      flag_mem[wr_idx] <= product_flags;
    end
  end

  assign out_flags_o = empty ? 4'b0000 : flag_mem[rd_idx];
`endif

  // Next-state for S1, pointers, occupancy and pop counter
  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tag_d   = s1_tag_q;
    wr_ptr_d   = wr_ptr_q + PW'(fifo_wr);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    count_d    = count_q;
    ops_done_d = ops_done_q + 16'(pop);

    if (accept) begin
      s1_a_d   = in_a_i;
      s1_b_d   = in_b_i;
      s1_tag_d = in_tag_i;
    end

    case ({fifo_wr, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    // Flush drops S1, the queue, and any coincident accept or pop
    if (flush_i) begin
      s1_valid_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ops_done_d = ops_done_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tag_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ops_done_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tag_q   <= s1_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Result storage; no reset needed since empty entries are never shown
  always_ff @(posedge clk) begin
    if (!rst && !flush_i && fifo_wr) begin
      res_mem[wr_idx] <= product;
      tag_mem[wr_idx] <= s1_tag_q;
    end
  end

endmodule

// FP32_Multiplier_Combinatorial: IEEE-754 single multiply, round to nearest even,
// subnormal inputs and outputs supported, every NaN result is 0x7FFFFFFF.
// Ports: a_i, b_i operands; result_o product.
module FP32_Multiplier_Combinatorial (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);
  logic              sign;
  logic [7:0]        exp_a, exp_b, eff_a, eff_b;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod, prod_n;
  logic [5:0]        lz;
  logic signed [9:0] exp_n, under;
  logic [5:0]        rsh;
  logic [7:0]        exp_base;
  logic [95:0]       shifted;
  logic              guard, sticky, round_up;
  logic [30:0]       mag;

  always_comb begin
    sign   = a_i[31] ^ b_i[31];
    exp_a  = a_i[30:23];
    exp_b  = b_i[30:23];
    a_nan  = (exp_a == 8'hFF) && (a_i[22:0] != 23'h0);
    b_nan  = (exp_b == 8'hFF) && (b_i[22:0] != 23'h0);
    a_inf  = (exp_a == 8'hFF) && (a_i[22:0] == 23'h0);
    b_inf  = (exp_b == 8'hFF) && (b_i[22:0] == 23'h0);
    a_zero = (exp_a == 8'h00) && (a_i[22:0] == 23'h0);
    b_zero = (exp_b == 8'h00) && (b_i[22:0] == 23'h0);
    // Subnormals use exponent 1 with no hidden bit
    eff_a  = (exp_a == 8'h00) ? 8'd1 : exp_a;
    eff_b  = (exp_b == 8'h00) ? 8'd1 : exp_b;

    prod = 48'({|exp_a, a_i[22:0]}) * 48'({|exp_b, b_i[22:0]});

    // Leading-zero count; highest set bit wins
    lz = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (prod[i]) lz = 6'(47 - i);
    end
    prod_n = prod << lz;

    exp_n = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b}) - 10'sd126
          - $signed({4'b0000, lz});
    under = 10'sd1 - exp_n;

    // Tiny results are denormalised by shifting right; 63 already clears everything
    if (exp_n > 10'sd0) begin
      rsh      = 6'd0;
      exp_base = 8'(exp_n - 10'sd1);
    end else begin
      rsh      = (under > 10'sd63) ? 6'd63 : under[5:0];
      exp_base = 8'h00;
    end

    shifted  = {prod_n, 48'h0} >> rsh;
    guard    = shifted[71];
    sticky   = |shifted[70:0];
    round_up = guard && (sticky || shifted[72]);
    // Hidden bit adds into the exponent field; rounding carry may bump exponent
    mag      = {exp_base, 23'h0} + 31'(shifted[95:72]) + 31'(round_up);

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      result_o = 32'h7FFF_FFFF;
    end else if (a_inf || b_inf) begin
      result_o = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      result_o = {sign, 31'h0};
    end else if (exp_n >= 10'sd255) begin
      result_o = {sign, 8'hFF, 23'h0};
    end else begin
      result_o = {sign, mag};
    end
  end

endmodule

// File: tb/tb_fp32_mul_stream.sv
// Bench for fp32_mul_stream: directed handshake/corner steps followed by a long
// randomized stream checked against an exact-arithmetic reference multiplier.
module tb_fp32_mul_stream;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned TW       = 8;
  localparam int unsigned N_STREAM = 70000;
  localparam int unsigned BUDGET   = 90000;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_a;
  logic [31:0]   in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_result;
  logic [TW-1:0] out_tag;
`ifdef FP32_MUL_FLAGS_EN
  logic [3:0]    out_flags;
`endif
  logic [15:0]   ops_done;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  int acc, npop, issued, cyc;
  logic seen;
  logic [31:0]   bp_res[$];
  logic [TW-1:0] bp_tag[$];
  logic [31:0]   q_res[$];
  logic [TW-1:0] q_tag[$];

  fp32_mul_stream #(.FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .in_tag_i     (in_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_result_o (out_result),
    .out_tag_o    (out_tag),
`ifdef FP32_MUL_FLAGS_EN
    .out_flags_o  (out_flags),
`endif
    .ops_done_o   (ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact value q*2^t rounded to the nearest single, ties to even
  function automatic logic [31:0] round_pack(input logic s, input longint unsigned m, input int e);
    int n, t, k, be;
    longint unsigned q, rem, half;
    n = 0;
    for (int i = 0; i < 64; i++) if (m[i]) n = i;
    if (e + n + 127 >= 1) t = e + n - 23;
    else t = -149;
    k = t - e;
    if (k <= 0) begin
      q = m << (-k);
    end else if (k > 60) begin
      q = 64'd0;
    end else begin
      q    = m >> k;
      rem  = m - (q << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    end
    if (q >= (64'd1 << 24)) begin
      q = q >> 1;
      t = t + 1;
    end
    if (q == 64'd0) return {s, 31'h0};
    if (q >= (64'd1 << 23)) begin
      be = t + 150;
      if (be >= 255) return {s, 8'hFF, 23'h0};
      return {s, be[7:0], q[22:0]};
    end
    return {s, 8'h00, q[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    longint unsigned ma, mb;
    int ea, eb;
    s      = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    a_zero = (a[30:0] == 0);
    b_zero = (b[30:0] == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FFF_FFFF;
    if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    ma = (a[30:23] == 0) ? 64'(a[22:0]) : (64'(a[22:0]) | (64'd1 << 23));
    mb = (b[30:23] == 0) ? 64'(b[22:0]) : (64'(b[22:0]) | (64'd1 << 23));
    ea = ((a[30:23] == 0) ? 1 : int'(a[30:23])) - 150;
    eb = ((b[30:23] == 0) ? 1 : int'(b[30:23])) - 150;
    return round_pack(s, ma * mb, ea + eb);
  endfunction

  function automatic logic [3:0] flags_of(input logic [31:0] r);
    logic [3:0] f;
    f[3] = (r[30:23] == 8'hFF) && (r[22:0] != 0);
    f[2] = (r[30:23] == 8'hFF) && (r[22:0] == 0);
    f[1] = (r[30:23] == 8'h00) && (r[22:0] == 0);
    f[0] = (r[30:23] == 8'h00) && (r[22:0] != 0);
    return f;
  endfunction

  // Operand mix biased toward zeros, specials, underflow and overflow ranges
  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: r[30:0]  = 31'h0;
      2: begin
        r[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 1) r[22:0] = 23'h0;
      end
      3: r[30:23] = 8'($urandom_range(30, 70));
      4: r[30:23] = 8'($urandom_range(150, 254));
      5: r[30:23] = 8'($urandom_range(100, 154));
      default: ;
    endcase
    return r;
  endfunction

  task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [TW-1:0] tag, input logic [31:0] exp_res,
                           input logic [3:0] exp_fl);
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check({name, "_result"}, out_result, exp_res);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
`ifdef FP32_MUL_FLAGS_EN
    check({name, "_flags"}, 32'(out_flags), 32'(exp_fl));
`else
    check({name, "_rflags"}, 32'(flags_of(out_result)), 32'(exp_fl));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_ops++;
    check({name, "_ops"}, 32'(ops_done), 32'(16'(exp_ops)));
    check({name, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_tag = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
`ifdef FP32_MUL_FLAGS_EN
    check("rst_out_flags", 32'(out_flags), 32'd0);
`endif
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Directed products
    single_op("basic", 32'h4040_0000, 32'h4000_0000, 8'h11, 32'h40C0_0000, 4'b0000);
    single_op("sign",  32'h3F80_0000, 32'hBF80_0000, 8'h22, 32'hBF80_0000, 4'b0000);
    single_op("nan",   32'h7FC0_0000, 32'h3F80_0000, 8'h33, 32'h7FFF_FFFF, 4'b1000);
    single_op("ovf",   32'h7F00_0000, 32'h7F00_0000, 8'h44, 32'h7F80_0000, 4'b0100);
    single_op("zero",  32'h0000_0000, 32'h4000_0000, 8'h55, 32'h0000_0000, 4'b0010);
    single_op("subn",  32'h0080_0000, 32'h3F00_0000, 8'h66, 32'h0040_0000, 4'b0001);
    single_op("infz",  32'hFF80_0000, 32'h0000_0000, 8'h77, 32'h7FFF_FFFF, 4'b1000);

    // Backpressure: six back-to-back offers with the consumer stalled
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_tag = TW'(8'h40 + i);
      if (in_ready) begin
        bp_res.push_back(ref_mul(in_a, in_b));
        bp_tag.push_back(in_tag);
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_rdy_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("bp_rdy_hold", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    npop = 0;
    for (int c = 0; c < 10 && npop < 4; c++) begin
      if (c == 0) check("bp_rdy_popcyc", 32'(in_ready), 32'd0);
      if (c == 1) check("bp_rdy_after", 32'(in_ready), 32'd1);
      if (out_valid && bp_res.size() != 0) begin
        check("bp_res", out_result, bp_res.pop_front());
        check("bp_tag", 32'(out_tag), 32'(bp_tag.pop_front()));
        npop++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    exp_ops += npop;
    check("bp_pops", 32'(npop), 32'd4);
    check("bp_ops", 32'(ops_done), 32'(16'(exp_ops)));
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush with three entries queued, plus a coincident pop and accept
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_tag = TW'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("fl_queued", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_tag = 8'hEE;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ops", 32'(ops_done), 32'(16'(exp_ops)));
    check("fl_rdy", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check("fl_discard", 32'(out_valid), 32'd0);

    // Reset while S1 holds an operand
    in_valid = 1'b1; in_a = 32'h4040_0000; in_b = 32'h4040_0000; in_tag = 8'h99;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check("mrst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("mrst_noresult", 32'(seen), 32'd0);
    check("mrst_ops", 32'(ops_done), 32'd0);

    // Long random stream with consumer stalls, wrapping ops_done
    issued = 0; cyc = 0;
    while ((issued < int'(N_STREAM) || q_res.size() != 0) && cyc < int'(BUDGET)) begin
      if (issued < int'(N_STREAM) && $urandom_range(0, 31) != 0) begin
        in_valid = 1'b1; in_a = rand_op(); in_b = rand_op(); in_tag = TW'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 15) != 0);
      if (in_valid && in_ready) begin
        q_res.push_back(ref_mul(in_a, in_b));
        q_tag.push_back(in_tag);
        issued++;
      end
      if (out_valid && out_ready) begin
        if (q_res.size() == 0) begin
          check("st_spurious", 32'(out_valid), 32'd0);
        end else begin
          check("st_res", out_result, q_res[0]);
          check("st_tag", 32'(out_tag), 32'(q_tag[0]));
`ifdef FP32_MUL_FLAGS_EN
          check("st_flags", 32'(out_flags), 32'(flags_of(q_res[0])));
`endif
          void'(q_res.pop_front());
          void'(q_tag.pop_front());
          exp_ops++;
        end
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("st_drained", 32'(q_res.size()), 32'd0);
    check("st_issued", 32'(issued), 32'(N_STREAM));
    check("st_ops_model", 32'(ops_done), 32'(16'(exp_ops)));
    check("st_ops_wrap", 32'(ops_done), 32'd4464);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
